// File: rtl/dfp_pkg.sv
// Shared constants, state encoding and operand struct for the double-precision add/sub unit.
package dfp_pkg;

  localparam int EXP_W     = 11;
  localparam int MAN_W     = 52;
  localparam int SIG_W     = MAN_W + 4;
  localparam int BIAS      = 1023;
  localparam int EXP_MAX   = 2047;
  localparam int SHIFT_CAP = 55;

  localparam logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000;

  localparam int FLAG_INVALID   = 0;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 2;
  localparam int FLAG_INEXACT   = 3;
  localparam int FLAG_ZERO      = 4;
  localparam int FLAG_INF       = 5;
  localparam int FLAG_NAN       = 6;
  localparam int FLAG_SIGN      = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  // sig layout: [55] hidden bit, [54:3] fraction, [2:0] guard/round/sticky
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } unpacked_t;

endpackage

// File: rtl/dfp_unpack.sv
// Splits one IEEE double into sign/exponent/significand and classifies it.
// Subnormals are reported as zero and carry a zero significand.
module dfp_unpack
  import dfp_pkg::*;
(
  input  logic [63:0] operand,
  output unpacked_t   fields,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);

  logic [EXP_W-1:0] exp_field;
  logic [MAN_W-1:0] frac;
  logic             exp_all_ones;

  assign exp_field    = operand[62:52];
  assign frac         = operand[51:0];
  assign exp_all_ones = &exp_field;

  assign is_zero = (exp_field == '0);
  assign is_inf  = exp_all_ones && (frac == '0);
  assign is_nan  = exp_all_ones && (frac != '0);

  always_comb begin
    fields.sign = operand[63];
    fields.exp  = exp_field;
    fields.sig  = is_zero ? '0 : {1'b1, frac, 3'b000};
  end

endmodule

// File: rtl/dfp_addsub_unit.sv
// Multi-cycle double-precision add/subtract unit with valid/ready on both sides.
// One operation in flight: align, add, bit-serial normalize, round-to-nearest-even.
module dfp_addsub_unit #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_res,
  output logic [7:0]       out_flags,
  output logic [TAG_W-1:0] out_tag
);

  import dfp_pkg::*;

  state_t           state;
  logic [63:0]      a_r, b_r;
  logic             op_r;
  logic [TAG_W-1:0] tag_r;
  logic [SIG_W-1:0] sig_r, sig_b_r;
  logic [11:0]      exp_r;
  logic             sign_r, sub_r, zero_r, zero_sign_r;

  unpacked_t ua, ub, ub_eff, big_op, small_op;
  logic      a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  dfp_unpack u_unpack_a (
    .operand (a_r),
    .fields  (ua),
    .is_zero (a_zero),
    .is_inf  (a_inf),
    .is_nan  (a_nan)
  );

  dfp_unpack u_unpack_b (
    .operand (b_r),
    .fields  (ub),
    .is_zero (b_zero),
    .is_inf  (b_inf),
    .is_nan  (b_nan)
  );

  logic [EXP_W-1:0] diff;
  logic [5:0]       sh;
  logic [SIG_W-1:0] shifted, lost_mask, aligned;
  logic             spec_hit;
  logic [63:0]      spec_res;
  logic [7:0]       spec_flags;

  // Operand swap, alignment shift with sticky collection, and special-value detection
  always_comb begin
    ub_eff      = ub;
    ub_eff.sign = ub.sign ^ op_r;
    if ({ua.exp, ua.sig} >= {ub.exp, ub.sig}) begin
      big_op   = ua;
      small_op = ub_eff;
    end else begin
      big_op   = ub_eff;
      small_op = ua;
    end
    diff      = big_op.exp - small_op.exp;
    sh        = (diff > 11'(SHIFT_CAP)) ? 6'(SHIFT_CAP) : diff[5:0];
    shifted   = small_op.sig >> sh;
    lost_mask = (56'd1 << sh) - 56'd1;
    aligned   = {shifted[SIG_W-1:1], shifted[0] | (|(small_op.sig & lost_mask))};

    spec_hit   = a_nan | b_nan | a_inf | b_inf;
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan) begin
      spec_res             = CANON_NAN;
      spec_flags[FLAG_NAN] = 1'b1;
    end else if (a_inf && b_inf && (ua.sign != ub_eff.sign)) begin
      spec_res                 = CANON_NAN;
      spec_flags[FLAG_NAN]     = 1'b1;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (a_inf) begin
      spec_res             = {ua.sign, 11'h7FF, 52'd0};
      spec_flags[FLAG_INF] = 1'b1;
    end else if (b_inf) begin
      spec_res             = {ub_eff.sign, 11'h7FF, 52'd0};
      spec_flags[FLAG_INF] = 1'b1;
    end
    spec_flags[FLAG_SIGN] = spec_res[63];
  end

  logic [SIG_W:0] sum;

  always_comb begin
    if (sub_r) sum = {1'b0, sig_r} - {1'b0, sig_b_r};
    else       sum = {1'b0, sig_r} + {1'b0, sig_b_r};
  end

  logic        inc, inexact, rnd_norm;
  logic [53:0] rnd;
  logic [11:0] rnd_exp;
  logic [51:0] rnd_frac;
  logic [63:0] round_res;
  logic [7:0]  round_flags;

  // Round-to-nearest-even; a hidden bit still clear after rounding means the result is subnormal
  always_comb begin
    inexact  = |sig_r[2:0];
    inc      = sig_r[2] & (sig_r[1] | sig_r[0] | sig_r[3]);
    rnd      = {1'b0, sig_r[SIG_W-1:3]} + {53'd0, inc};
    rnd_exp  = exp_r + {11'd0, rnd[53]};
    rnd_frac = rnd[53] ? rnd[52:1] : rnd[51:0];
    rnd_norm = rnd[53] | rnd[52];

    round_res   = '0;
    round_flags = '0;
    if (zero_r) begin
      round_res              = {zero_sign_r, 63'd0};
      round_flags[FLAG_ZERO] = 1'b1;
    end else if (rnd_exp >= 12'(EXP_MAX)) begin
      round_res                  = {sign_r, 11'h7FF, 52'd0};
      round_flags[FLAG_OVERFLOW] = 1'b1;
      round_flags[FLAG_INEXACT]  = 1'b1;
      round_flags[FLAG_INF]      = 1'b1;
    end else if (!rnd_norm) begin
      round_res                   = {sign_r, 63'd0};
      round_flags[FLAG_UNDERFLOW] = 1'b1;
      round_flags[FLAG_INEXACT]   = 1'b1;
      round_flags[FLAG_ZERO]      = 1'b1;
    end else begin
      round_res                 = {sign_r, rnd_exp[10:0], rnd_frac};
      round_flags[FLAG_INEXACT] = inexact;
    end
    round_flags[FLAG_SIGN] = round_res[63];
  end

  // Control FSM; a special result enters DONE with out_valid low and raises it one clock later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_res     <= '0;
      out_flags   <= '0;
      out_tag     <= '0;
      a_r         <= '0;
      b_r         <= '0;
      op_r        <= 1'b0;
      tag_r       <= '0;
      sig_r       <= '0;
      sig_b_r     <= '0;
      exp_r       <= '0;
      sign_r      <= 1'b0;
      sub_r       <= 1'b0;
      zero_r      <= 1'b0;
      zero_sign_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= in_a;
            b_r      <= in_b;
            op_r     <= in_op;
            tag_r    <= in_tag;
            in_ready <= 1'b0;
            state    <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (spec_hit) begin
            out_res   <= spec_res;
            out_flags <= spec_flags;
            out_tag   <= tag_r;
            state     <= S_DONE;
          end else begin
            sig_r       <= big_op.sig;
            sig_b_r     <= aligned;
            exp_r       <= {1'b0, big_op.exp};
            sign_r      <= big_op.sign;
            sub_r       <= big_op.sign ^ small_op.sign;
            zero_r      <= 1'b0;
            zero_sign_r <= a_zero & b_zero & ua.sign & ub_eff.sign;
            state       <= S_ADD;
          end
        end
        S_ADD: begin
          if (sum[SIG_W]) begin
            sig_r <= {sum[SIG_W:2], sum[1] | sum[0]};
            exp_r <= exp_r + 12'd1;
          end else begin
            sig_r <= sum[SIG_W-1:0];
          end
          state <= S_NORM;
        end
        S_NORM: begin
          if (sig_r == '0) begin
            zero_r <= 1'b1;
            state  <= S_ROUND;
          end else if (!sig_r[SIG_W-1] && (exp_r > 12'd1)) begin
            sig_r <= sig_r << 1;
            exp_r <= exp_r - 12'd1;
          end else begin
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          out_res   <= round_res;
          out_flags <= round_flags;
          out_tag   <= tag_r;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dfp_addsub_unit.sv
// Directed bench for dfp_addsub_unit: vector table plus backpressure and mid-operation reset sequences.
module tb_dfp_addsub_unit;

  localparam int TAG_W = 4;
  localparam int NVEC  = 15;
  localparam int WAIT_LIMIT = 200;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [63:0]      in_a;
  logic [63:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_res;
  logic [7:0]       out_flags;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  dfp_addsub_unit #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flags (out_flags),
    .out_tag   (out_tag)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic             op;
    logic [63:0]      a;
    logic [63:0]      b;
    logic [TAG_W-1:0] tag;
    logic [63:0]      res;
    logic [7:0]       flags;
    int               lat;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic op, input logic [63:0] a, input logic [63:0] b,
                               input logic [TAG_W-1:0] tag);
    int guard_cnt;
    guard_cnt = 0;
    @(negedge clk);
    while (!in_ready && guard_cnt < WAIT_LIMIT) begin
      @(negedge clk);
      guard_cnt++;
    end
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < WAIT_LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handoff(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({name, "_valid_drop"}, 64'(out_valid), 64'd0);
    checkOutput({name, "_ready_rise"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int  lat;
    bit  seen_valid;

    //          op    a                      b                      tag    res                    flags  lat
    vecs[0]  = '{1'b1, 64'h4023800000000000, 64'h3FE2000000000000, 4'd3, 64'h4022600000000000, 8'h00, 4};
    vecs[1]  = '{1'b1, 64'h3FF0000000000001, 64'h3FF0000000000000, 4'd5, 64'h3CB0000000000000, 8'h00, 56};
    vecs[2]  = '{1'b1, 64'h7FF0000000000000, 64'h7FF0000000000000, 4'd1, 64'h7FF8000000000000, 8'h41, 2};
    vecs[3]  = '{1'b0, 64'h7FF0000000000001, 64'h3FF0000000000000, 4'd2, 64'h7FF8000000000000, 8'h40, 2};
    vecs[4]  = '{1'b0, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 4'd4, 64'h7FF0000000000000, 8'h2A, 4};
    vecs[5]  = '{1'b0, 64'h3FF0000000000000, 64'h3FF0000000000000, 4'd6, 64'h4000000000000000, 8'h00, 4};
    vecs[6]  = '{1'b1, 64'h3FF0000000000000, 64'h3FF0000000000000, 4'd7, 64'h0000000000000000, 8'h10, 4};
    vecs[7]  = '{1'b0, 64'h8000000000000000, 64'h8000000000000000, 4'd8, 64'h8000000000000000, 8'h90, 4};
    vecs[8]  = '{1'b0, 64'hBFF0000000000000, 64'h3FF0000000000000, 4'd9, 64'h0000000000000000, 8'h10, 4};
    vecs[9]  = '{1'b0, 64'h7FF0000000000000, 64'h3FF0000000000000, 4'd10, 64'h7FF0000000000000, 8'h20, 2};
    vecs[10] = '{1'b1, 64'h3FF0000000000000, 64'h7FF0000000000000, 4'd11, 64'hFFF0000000000000, 8'hA0, 2};
    vecs[11] = '{1'b0, 64'h3FF0000000000000, 64'h3CA0000000000000, 4'd12, 64'h3FF0000000000000, 8'h08, 4};
    vecs[12] = '{1'b0, 64'h3FF0000000000001, 64'h3CA0000000000000, 4'd13, 64'h3FF0000000000002, 8'h08, 4};
    vecs[13] = '{1'b0, 64'h3FF0000000000000, 64'h0000000000000001, 4'd14, 64'h3FF0000000000000, 8'h00, 4};
    vecs[14] = '{1'b1, 64'h0010000000000001, 64'h0010000000000000, 4'd15, 64'h0000000000000000, 8'h1C, 4};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready",  64'(in_ready),  64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_res",   out_res,        64'd0);
    checkOutput("reset_out_flags", 64'(out_flags), 64'd0);
    checkOutput("reset_out_tag",   64'(out_tag),   64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      waitResult(lat);
      checkOutput($sformatf("v%0d_res", i),     out_res,         vecs[i].res);
      checkOutput($sformatf("v%0d_flags", i),   64'(out_flags),  64'(vecs[i].flags));
      checkOutput($sformatf("v%0d_tag", i),     64'(out_tag),    64'(vecs[i].tag));
      checkOutput($sformatf("v%0d_latency", i), 64'(lat),        64'(vecs[i].lat));
      handoff($sformatf("v%0d", i));
    end

    $display("[TB] backpressure sequence");
    applyStimulus(1'b1, 64'h4023800000000000, 64'h3FE2000000000000, 4'd7);
    waitResult(lat);
    checkOutput("bp_first_latency", 64'(lat), 64'd4);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 1'b0;
    in_a     = 64'h3FF0000000000000;
    in_b     = 64'h3FF0000000000000;
    in_tag   = 4'd9;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_hold%0d_res", c),   out_res,         64'h4022600000000000);
      checkOutput($sformatf("bp_hold%0d_tag", c),   64'(out_tag),    64'd7);
      checkOutput($sformatf("bp_hold%0d_ready", c), 64'(in_ready),   64'd0);
      checkOutput($sformatf("bp_hold%0d_valid", c), 64'(out_valid),  64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp_release_valid", 64'(out_valid), 64'd0);
    checkOutput("bp_bubble_ready",  64'(in_ready),  64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp_second_accepted", 64'(in_ready), 64'd0);
    waitResult(lat);
    checkOutput("bp_second_res",     out_res,      64'h4000000000000000);
    checkOutput("bp_second_tag",     64'(out_tag), 64'd9);
    checkOutput("bp_second_latency", 64'(lat),     64'd4);
    handoff("bp_second");

    $display("[TB] mid-operation reset sequence");
    applyStimulus(1'b1, 64'h3FF0000000000001, 64'h3FF0000000000000, 4'd5);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_reset_ready", 64'(in_ready),  64'd1);
    checkOutput("mid_reset_res",   out_res,        64'd0);
    checkOutput("mid_reset_flags", 64'(out_flags), 64'd0);
    checkOutput("mid_reset_tag",   64'(out_tag),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid = 1'b1;
    end
    checkOutput("mid_reset_no_stale_valid", 64'(seen_valid), 64'd0);

    applyStimulus(1'b0, 64'h3FF0000000000000, 64'h3FF0000000000000, 4'd2);
    waitResult(lat);
    checkOutput("post_reset_res",     out_res,      64'h4000000000000000);
    checkOutput("post_reset_tag",     64'(out_tag), 64'd2);
    checkOutput("post_reset_latency", 64'(lat),     64'd4);
    handoff("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
